// File: rtl/cache_pkg.sv
// Shared types and widths for the set-associative write-back cache.
package cache_pkg;

    localparam int unsigned LINE_W = 128;
    localparam int unsigned WORD_W = 32;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WB     = 2'd1,
        REFILL = 2'd2
    } cache_state_e;

endpackage

// File: rtl/cache_plru.sv
// Per-set replacement state: 1-bit LRU for 2 ways, 3-bit tree pseudo-LRU for 4 ways.
// Victim is the lowest-numbered invalid way, otherwise the least-recently-used way.
module cache_plru #(
    parameter int unsigned WAYS = 2
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic                     i_update,
    input  logic [$clog2(WAYS)-1:0]  i_way,
    input  logic [WAYS-1:0]          i_valid,
    output logic [$clog2(WAYS)-1:0]  o_victim
);

    localparam int unsigned WAY_W = $clog2(WAYS);

    logic [WAY_W-1:0] w_lru_way;

    generate
        if (WAYS == 4) begin : g_tree
            // Each tree bit points at the less-recently-used half below it.
            logic [2:0] r_tree;

            always_ff @(posedge i_clk or negedge i_rst_n) begin
                if (!i_rst_n) begin
                    r_tree <= '0;
                end else if (i_update) begin
                    r_tree[0] <= ~i_way[1];
                    if (i_way[1]) begin
                        r_tree[2] <= ~i_way[0];
                    end else begin
                        r_tree[1] <= ~i_way[0];
                    end
                end
            end

            assign w_lru_way = r_tree[0] ? {1'b1, r_tree[2]} : {1'b0, r_tree[1]};
        end else begin : g_bit
            logic r_lru;

            always_ff @(posedge i_clk or negedge i_rst_n) begin
                if (!i_rst_n) begin
                    r_lru <= 1'b0;
                end else if (i_update) begin
                    r_lru <= ~i_way[0];
                end
            end

            assign w_lru_way = r_lru;
        end
    endgenerate

    always_comb begin
        o_victim = w_lru_way;
        for (int w = int'(WAYS) - 1; w >= 0; w--) begin
            if (!i_valid[w]) begin
                o_victim = WAY_W'(w);
            end
        end
    end

endmodule

// File: rtl/assoc_cache.sv
// Set-associative write-back, write-allocate cache with 4-word lines.
// Optional hit/miss counters are enabled by defining ASSOC_CACHE_STATS_EN.
module assoc_cache
    import cache_pkg::*;
#(
    parameter int unsigned WAYS   = 2,
    parameter int unsigned SETS   = 4,
    parameter int unsigned ADDR_W = 30
) (
    input  logic              clk,
    input  logic              proc_reset_n,
    input  logic              proc_read,
    input  logic              proc_write,
    input  logic [ADDR_W-1:0] proc_addr,
    input  logic [WORD_W-1:0] proc_wdata,
    output logic              proc_stall,
    output logic [WORD_W-1:0] proc_rdata,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-3:0] mem_addr,
    input  logic [LINE_W-1:0] mem_rdata,
    output logic [LINE_W-1:0] mem_wdata,
    input  logic              mem_ready
`ifdef ASSOC_CACHE_STATS_EN
    ,
    output logic [31:0]       stat_hit,
    output logic [31:0]       stat_miss
`endif
);

    localparam int unsigned WAY_W = $clog2(WAYS);
    localparam int unsigned IDX_W = $clog2(SETS);
    localparam int unsigned TAG_W = ADDR_W - 2 - IDX_W;

    cache_state_e                r_state;
    logic [SETS-1:0][WAYS-1:0]   r_valid;
    logic [SETS-1:0][WAYS-1:0]   r_dirty;
    logic [TAG_W-1:0]            r_tag  [SETS][WAYS];
    logic [LINE_W-1:0]           r_data [SETS][WAYS];
    logic [WAY_W-1:0]            r_victim;

    logic [TAG_W-1:0]  w_tag;
    logic [IDX_W-1:0]  w_idx;
    logic [6:0]        w_bit;
    logic              w_req;
    logic              w_hit;
    logic [WAY_W-1:0]  w_hit_way;
    logic [WAY_W-1:0]  w_victim_set [SETS];
    logic [WAY_W-1:0]  w_victim;
    logic              w_vic_dirty;
    logic              w_idle_hit;
    logic              w_idle_miss;
    logic              w_wb_done;
    logic              w_rf_done;
    logic              w_lru_upd;
    logic [WAY_W-1:0]  w_lru_way;
    logic [LINE_W-1:0] w_hit_line;
    logic [LINE_W-1:0] w_fill;

    assign w_tag = proc_addr[ADDR_W-1 -: TAG_W];
    assign w_idx = proc_addr[2 +: IDX_W];
    assign w_bit = {proc_addr[1:0], 5'b0};
    assign w_req = proc_read | proc_write;

    always_comb begin
        w_hit     = 1'b0;
        w_hit_way = '0;
        for (int w = 0; w < int'(WAYS); w++) begin
            if (r_valid[w_idx][w] && (r_tag[w_idx][w] == w_tag)) begin
                w_hit     = 1'b1;
                w_hit_way = WAY_W'(w);
            end
        end
    end

    assign w_victim    = w_victim_set[w_idx];
    assign w_vic_dirty = r_valid[w_idx][w_victim] & r_dirty[w_idx][w_victim];
    assign w_idle_hit  = (r_state == IDLE) && w_req && w_hit;
    assign w_idle_miss = (r_state == IDLE) && w_req && !w_hit;
    assign w_wb_done   = (r_state == WB) && mem_ready;
    assign w_rf_done   = (r_state == REFILL) && mem_ready;
    assign w_lru_upd   = w_idle_hit || w_rf_done;
    assign w_lru_way   = (r_state == IDLE) ? w_hit_way : r_victim;
    assign w_hit_line  = r_data[w_idx][w_hit_way];

    // Write misses allocate: the store word is merged into the incoming line.
    always_comb begin
        w_fill = mem_rdata;
        if (proc_write) begin
            w_fill[w_bit +: WORD_W] = proc_wdata;
        end
    end

    for (genvar s = 0; s < SETS; s++) begin : g_set
        cache_plru #(
            .WAYS (WAYS)
        ) u_plru (
            .i_clk    (clk),
            .i_rst_n  (proc_reset_n),
            .i_update (w_lru_upd && (w_idx == IDX_W'(s))),
            .i_way    (w_lru_way),
            .i_valid  (r_valid[s]),
            .o_victim (w_victim_set[s])
        );
    end

    always_ff @(posedge clk or negedge proc_reset_n) begin
        if (!proc_reset_n) begin
            r_state  <= IDLE;
            r_victim <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_idle_miss) begin
                        r_victim <= w_victim;
                        r_state  <= w_vic_dirty ? WB : REFILL;
                    end
                end
                WB:      if (mem_ready) r_state <= REFILL;
                REFILL:  if (mem_ready) r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge proc_reset_n) begin
        if (!proc_reset_n) begin
            r_valid <= '0;
            r_dirty <= '0;
        end else begin
            if (w_idle_hit && proc_write) begin
                r_dirty[w_idx][w_hit_way] <= 1'b1;
            end
            if (w_wb_done) begin
                r_dirty[w_idx][r_victim] <= 1'b0;
            end
            if (w_rf_done) begin
                r_valid[w_idx][r_victim] <= 1'b1;
                r_dirty[w_idx][r_victim] <= proc_write;
            end
        end
    end

    // Tag and data arrays carry no reset; valid bits qualify them.
    always_ff @(posedge clk) begin
        if (w_idle_hit && proc_write) begin
            r_data[w_idx][w_hit_way][w_bit +: WORD_W] <= proc_wdata;
        end
        if (w_rf_done) begin
            r_data[w_idx][r_victim] <= w_fill;
            r_tag[w_idx][r_victim]  <= w_tag;
        end
    end

    always_comb begin
        proc_stall = 1'b0;
        proc_rdata = '0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        mem_addr   = '0;
        mem_wdata  = '0;
        if (proc_reset_n) begin
            case (r_state)
                IDLE: begin
                    if (w_req && w_hit) begin
                        if (!proc_write) proc_rdata = w_hit_line[w_bit +: WORD_W];
                    end else if (w_req) begin
                        proc_stall = 1'b1;
                        if (!w_vic_dirty) begin
                            mem_read = 1'b1;
                            mem_addr = proc_addr[ADDR_W-1:2];
                        end
                    end
                end
                WB: begin
                    proc_stall = 1'b1;
                    mem_write  = 1'b1;
                    mem_addr   = {r_tag[w_idx][r_victim], w_idx};
                    mem_wdata  = r_data[w_idx][r_victim];
                end
                REFILL: begin
                    mem_read = 1'b1;
                    mem_addr = proc_addr[ADDR_W-1:2];
                    if (mem_ready) begin
                        if (!proc_write) proc_rdata = mem_rdata[w_bit +: WORD_W];
                    end else begin
                        proc_stall = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef ASSOC_CACHE_STATS_EN
    logic [31:0] r_stat_hit;
    logic [31:0] r_stat_miss;

    always_ff @(posedge clk or negedge proc_reset_n) begin
        if (!proc_reset_n) begin
            r_stat_hit  <= '0;
            r_stat_miss <= '0;
        end else begin
            if (w_idle_hit && (r_stat_hit != 32'hFFFF_FFFF)) r_stat_hit <= r_stat_hit + 32'd1;
            if (w_idle_miss && (r_stat_miss != 32'hFFFF_FFFF)) r_stat_miss <= r_stat_miss + 32'd1;
        end
    end

    assign stat_hit  = r_stat_hit;
    assign stat_miss = r_stat_miss;
`endif

endmodule

// File: tb/tb_assoc_cache.sv
// Directed bench for assoc_cache (WAYS=2, SETS=4, ADDR_W=30) with a read-data scoreboard
// and a reference memory image; stat checks are compiled when ASSOC_CACHE_STATS_EN is set.
module tb_assoc_cache;

    logic          clk = 1'b0;
    logic          proc_reset_n;
    logic          proc_read;
    logic          proc_write;
    logic [29:0]   proc_addr;
    logic [31:0]   proc_wdata;
    logic          proc_stall;
    logic [31:0]   proc_rdata;
    logic          mem_read;
    logic          mem_write;
    logic [27:0]   mem_addr;
    logic [127:0]  mem_rdata;
    logic [127:0]  mem_wdata;
    logic          mem_ready;
`ifdef ASSOC_CACHE_STATS_EN
    logic [31:0]   stat_hit;
    logic [31:0]   stat_miss;
`endif

    int total = 0;
    int bad   = 0;
    int wb_count = 0;

    logic [31:0]  rd_q[$];
    logic [31:0]  ref_mem [logic [29:0]];
    logic [127:0] backing [logic [27:0]];

    always #5 clk = ~clk;

    assoc_cache #(
        .WAYS   (2),
        .SETS   (4),
        .ADDR_W (30)
    ) dut (
        .clk          (clk),
        .proc_reset_n (proc_reset_n),
        .proc_read    (proc_read),
        .proc_write   (proc_write),
        .proc_addr    (proc_addr),
        .proc_wdata   (proc_wdata),
        .proc_stall   (proc_stall),
        .proc_rdata   (proc_rdata),
        .mem_read     (mem_read),
        .mem_write    (mem_write),
        .mem_addr     (mem_addr),
        .mem_rdata    (mem_rdata),
        .mem_wdata    (mem_wdata),
        .mem_ready    (mem_ready)
`ifdef ASSOC_CACHE_STATS_EN
        ,
        .stat_hit     (stat_hit),
        .stat_miss    (stat_miss)
`endif
    );

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Initial memory image; line 0x4 holds the 0x00/0x11/0x22/0x33 pattern.
    function automatic logic [31:0] init_word(input logic [29:0] a);
        if (a[29:2] == 28'h4) begin
            case (a[1:0])
                2'd0:    return 32'h00;
                2'd1:    return 32'h11;
                2'd2:    return 32'h22;
                default: return 32'h33;
            endcase
        end
        return {2'b10, a[29:2], a[1:0]};
    endfunction

    function automatic logic [31:0] ref_word(input logic [29:0] a);
        if (ref_mem.exists(a)) return ref_mem[a];
        return init_word(a);
    endfunction

    function automatic logic [127:0] ref_line(input logic [27:0] line);
        logic [127:0] l;
        for (int n = 0; n < 4; n++) l[32*n +: 32] = ref_word({line, 2'(n)});
        return l;
    endfunction

    function automatic logic [127:0] mem_line(input logic [27:0] line);
        logic [127:0] l;
        if (backing.exists(line)) return backing[line];
        for (int n = 0; n < 4; n++) l[32*n +: 32] = init_word({line, 2'(n)});
        return l;
    endfunction

    // One processor request, serviced by the bench memory with the given latency.
    task automatic access(input string tag, input logic wr, input logic rd_too,
                          input logic [29:0] a, input logic [31:0] wd, input logic exp_hit,
                          input logic exp_wb, input logic [27:0] wb_line, input int lat);
        int cnt = 0;
        int cyc = 0;
        logic done;
        logic wb_seen = 1'b0;
        logic [31:0] exp;
        proc_read  = !wr || rd_too;
        proc_write = wr;
        proc_addr  = a;
        proc_wdata = wd;
        if (wr) ref_mem[a] = wd;
        else rd_q.push_back(ref_word(a));
        @(negedge clk);
        chk({tag, ".stall"}, proc_stall, !exp_hit);
        if (exp_hit) chk({tag, ".nomem"}, {mem_read, mem_write}, 2'b00);
        done = !proc_stall;
        while (!done && cyc < 64) begin
            cyc++;
            if (mem_write) begin
                chk({tag, ".wb_addr"}, mem_addr, wb_line);
                chk({tag, ".wb_data"}, mem_wdata, ref_line(wb_line));
            end
            if (mem_read) chk({tag, ".rf_addr"}, mem_addr, a[29:2]);
            if (mem_read || mem_write) begin
                cnt++;
                if (cnt >= lat) begin
                    cnt = 0;
                    if (mem_write) begin
                        backing[mem_addr] = mem_wdata;
                        wb_seen = 1'b1;
                        wb_count++;
                    end else begin
                        mem_rdata = mem_line(mem_addr);
                    end
                    mem_ready = 1'b1;
                    #1;
                    done = !proc_stall;
                end
            end
            if (!done) begin
                @(posedge clk);
                #1;
                mem_ready = 1'b0;
                @(negedge clk);
            end
        end
        chk({tag, ".done"}, done, 1'b1);
        chk({tag, ".wb"}, wb_seen, exp_wb);
        if (!wr) begin
            exp = rd_q.pop_front();
            chk({tag, ".rdata"}, proc_rdata, exp);
        end else begin
            chk({tag, ".wr_rdata"}, proc_rdata, 32'h0);
        end
        @(posedge clk);
        #1;
        mem_ready  = 1'b0;
        proc_read  = 1'b0;
        proc_write = 1'b0;
    endtask

    task automatic reset_pulse();
        proc_reset_n = 1'b0;
        @(posedge clk);
        #1;
        proc_reset_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int wb_before;
        proc_reset_n = 1'b0;
        proc_read    = 1'b1;
        proc_write   = 1'b0;
        proc_addr    = 30'h10;
        proc_wdata   = '0;
        mem_rdata    = '0;
        mem_ready    = 1'b0;
        #2;
        chk("rst.stall", proc_stall, 1'b0);
        chk("rst.mem_read", mem_read, 1'b0);
        chk("rst.mem_write", mem_write, 1'b0);
        chk("rst.rdata", proc_rdata, 32'h0);
        chk("rst.mem_addr", mem_addr, 28'h0);
        chk("rst.mem_wdata", mem_wdata, 128'h0);
        repeat (2) @(posedge clk);
        #1;
        proc_read    = 1'b0;
        proc_reset_n = 1'b1;
        @(posedge clk);
        #1;

        access("cold_rd_10", 1'b0, 1'b0, 30'h10, 32'h0, 1'b0, 1'b0, 28'h0, 3);
        access("hit_rd_11", 1'b0, 1'b0, 30'h11, 32'h0, 1'b1, 1'b0, 28'h0, 1);
`ifdef ASSOC_CACHE_STATS_EN
        chk("stat_hit", stat_hit, 32'd1);
        chk("stat_miss", stat_miss, 32'd1);
`endif
        access("wr_hit_12", 1'b1, 1'b0, 30'h12, 32'hDEADBEEF, 1'b1, 1'b0, 28'h0, 1);
        access("rd_hit_12", 1'b0, 1'b0, 30'h12, 32'h0, 1'b1, 1'b0, 28'h0, 1);
        access("fill_20", 1'b0, 1'b0, 30'h20, 32'h0, 1'b0, 1'b0, 28'h0, 2);
        access("evict_30", 1'b0, 1'b0, 30'h30, 32'h0, 1'b0, 1'b1, 28'h4, 2);
        access("reload_12", 1'b0, 1'b0, 30'h12, 32'h0, 1'b0, 1'b0, 28'h0, 2);

        reset_pulse();
        wb_before = wb_count;
        access("lru_10", 1'b0, 1'b0, 30'h10, 32'h0, 1'b0, 1'b0, 28'h0, 2);
        access("lru_20", 1'b0, 1'b0, 30'h20, 32'h0, 1'b0, 1'b0, 28'h0, 2);
        access("lru_hit_10", 1'b0, 1'b0, 30'h10, 32'h0, 1'b1, 1'b0, 28'h0, 1);
        access("lru_30", 1'b0, 1'b0, 30'h30, 32'h0, 1'b0, 1'b0, 28'h0, 2);
        access("lru_keep_10", 1'b0, 1'b0, 30'h10, 32'h0, 1'b1, 1'b0, 28'h0, 1);
        access("lru_gone_20", 1'b0, 1'b0, 30'h20, 32'h0, 1'b0, 1'b0, 28'h0, 2);
        chk("lru.no_wb", wb_count, wb_before);

        access("wr_miss_25", 1'b1, 1'b0, 30'h25, 32'hCAFE0025, 1'b0, 1'b0, 28'h0, 2);
        access("rd_hit_25", 1'b0, 1'b0, 30'h25, 32'h0, 1'b1, 1'b0, 28'h0, 1);
        access("rd_hit_24", 1'b0, 1'b0, 30'h24, 32'h0, 1'b1, 1'b0, 28'h0, 1);
        access("rdwr_26", 1'b1, 1'b1, 30'h26, 32'h1234_5678, 1'b1, 1'b0, 28'h0, 1);
        access("rd_hit_26", 1'b0, 1'b0, 30'h26, 32'h0, 1'b1, 1'b0, 28'h0, 1);

        // Abandon a refill by asserting reset while it is in flight.
        proc_read = 1'b1;
        proc_addr = 30'h40;
        @(negedge clk);
        chk("rfrst.detect", {proc_stall, mem_read}, 2'b11);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("rfrst.refill", {proc_stall, mem_read}, 2'b11);
        proc_reset_n = 1'b0;
        #1;
        chk("rfrst.mem_read", mem_read, 1'b0);
        chk("rfrst.stall", proc_stall, 1'b0);
        chk("rfrst.mem_addr", mem_addr, 28'h0);
        @(posedge clk);
        #1;
        proc_read    = 1'b0;
        proc_reset_n = 1'b1;
        @(posedge clk);
        #1;
        access("rfrst.remiss_40", 1'b0, 1'b0, 30'h40, 32'h0, 1'b0, 1'b0, 28'h0, 2);

        chk("sb_empty", rd_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/assoc_cache.md
ASSOC_CACHE -- requirements
Module: assoc_cache

Interface
REQ-001 SHALL have parameter WAYS, default 2, associativity; legal values 2 or 4.
REQ-002 SHALL have parameter SETS, default 4, number of sets; power of two, at least 2.
REQ-003 SHALL have parameter ADDR_W, default 30, processor word-address width.
REQ-004 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-005 SHALL have port proc_reset_n  input  1  asynchronous, active-low reset.
REQ-006 SHALL have ports proc_read, proc_write  input  1 each  processor request strobes.
REQ-007 SHALL have port proc_addr  input  ADDR_W  word address: tag, then index (log2 SETS bits), then offset [1:0].
REQ-008 SHALL have port proc_wdata  input  32  store data.
REQ-009 SHALL have port proc_stall  output  1  request not yet complete.
REQ-010 SHALL have port proc_rdata  output  32  load data, valid when proc_read is high and proc_stall is low.
REQ-011 SHALL have ports mem_read, mem_write  output  1 each  memory line request.
REQ-012 SHALL have port mem_addr  output  ADDR_W-2  line address.
REQ-013 SHALL have ports mem_rdata  input  128 and mem_wdata  output  128  line data; word n occupies bits [32n+31:32n].
REQ-014 SHALL have port mem_ready  input  1  memory request complete this cycle.

Function
REQ-015 SHALL use states IDLE, WB and REFILL; reset state IDLE.
REQ-016 SHALL treat a request as a hit when any way in the indexed set is valid and its tag equals the request tag.
- Read hit: proc_rdata is the addressed word in the same cycle, proc_stall=0.
- Write hit: the addressed word is updated, dirty is set, proc_stall=0.
REQ-017 SHALL update replacement state on every hit and every refill so that the accessed way becomes most-recently-used.
- WAYS=2: 1 bit per set.
- WAYS=4: 3-bit tree pseudo-LRU per set.
REQ-018 SHALL choose the victim on a miss as follows: the lowest-numbered invalid way; otherwise the LRU way.
REQ-019 SHALL handle a miss with a dirty victim by entering WB.
- mem_write=1, mem_addr={victim tag, index}, mem_wdata=victim line, held until mem_ready.
- On mem_ready: clear victim dirty, go to REFILL.
REQ-020 SHALL handle a miss with a clean or invalid victim by entering REFILL directly, with mem_read=1 asserted in the same cycle the miss is detected.
REQ-021 SHALL behave in REFILL as follows: mem_read=1, mem_addr=proc_addr[ADDR_W-1:2], held until mem_ready.
- On mem_ready: install the line into the victim way; valid=1; tag written.
- For a write miss, proc_wdata is merged into the line and dirty=1; otherwise dirty=0.
- For a read miss, proc_rdata=mem_rdata word at offset.
- proc_stall=0 in that same cycle; return to IDLE.
REQ-022 SHALL hold proc_stall=1 in every other WB/REFILL cycle and on the IDLE miss-detection cycle; the processor holds the request stable while stalled.
REQ-023 SHALL treat proc_read and proc_write asserted together as a write.
REQ-024 SHALL sample mem_ready only in WB and REFILL; it is ignored in IDLE.
REQ-025 SHALL drive mem_read=0, mem_write=0, proc_stall=0, proc_rdata=0, mem_addr=0 and mem_wdata=0 when idle or when there is no request.

Reset
REQ-026 SHALL, while proc_reset_n=0 and regardless of clk, clear all valid, dirty and LRU bits, force state IDLE, and drive all outputs to 0; tag and data arrays need not be reset.
REQ-027 SHALL abandon an in-flight WB/REFILL when reset is asserted mid-operation, dropping mem_read/mem_write immediately with no partial line installed.

Configuration
REQ-028 SHALL, with macro ASSOC_CACHE_STATS_EN defined, add outputs stat_hit and stat_miss, each 32-bit.
- stat_hit increments once per IDLE hit.
- stat_miss increments once per IDLE miss detection.
- Both saturate at 0xFFFFFFFF and reset to 0.
REQ-029 SHALL, without ASSOC_CACHE_STATS_EN, have no counter ports or logic.

Structure
REQ-030 SHALL place the state enum, LINE_W=128 and WORD_W=32 in shared package cache_pkg.
REQ-031 SHALL implement replacement update and victim selection in sub-module cache_plru, parameterised by WAYS and instantiated once per set or as an array.

Verification (WAYS=2, SETS=4, ADDR_W=30)
REQ-032 SHALL cover cold read miss.
- Stimulus: after reset, read 0x10; mem_ready after 3 cycles with mem_rdata={0x33,0x22,0x11,0x00} (word3..word0).
- Response: mem_read=1 and mem_addr=0x4 throughout; proc_rdata=0x00 with stall=0 in the ready cycle.
- Follow-up: read 0x11 hits with no stall, returns 0x11.
REQ-033 SHALL cover write hit: write 0x12 with 0xDEADBEEF -> no stall, no memory access; read 0x12 -> 0xDEADBEEF.
REQ-034 SHALL cover LRU victim choice.
- Stimulus: fill set 0 with 0x10 and 0x20; read 0x10; read 0x30.
- Response: way holding 0x20 is replaced with no mem_write; read 0x10 still hits.
REQ-035 SHALL cover dirty eviction.
- Stimulus: after REQ-033, miss on set 0 with 0x10 as LRU.
- Response: mem_write=1, mem_addr=0x4, mem_wdata word2=0xDEADBEEF; after mem_ready, mem_read with new line address.
REQ-036 SHALL cover reset during REFILL: assert proc_reset_n=0 -> mem_read=0 and proc_stall=0 immediately; after release, read of the same address misses again.
REQ-037 SHALL cover statistics: with ASSOC_CACHE_STATS_EN, after REQ-032 -> stat_hit=1, stat_miss=1.
